seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 2-bit-state `sequence` detector.
- Adds:
  - pattern width set by parameter
  - pattern reloadable at run time
  - overlap / non-overlap mode
  - input qualifier (`in_valid`)
  - saturating match counter
- Sits on a serial data line, for example after a deserialiser or UART RX. Flags each occurrence of the programmed pattern to downstream control logic.

Parameters:
- PAT_W, 4: pattern length in bits; legal range 2..16.
- PAT_RST, 4'b1001: pattern loaded at reset; PAT_W bits wide; MSB is matched first.
- OVERLAP, 1: 1 = overlapping matches counted; 0 = history discarded after each match.
- CNT_W, 8: match counter width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input_bit is sampled on this edge
- input_bit  in  1  serial data bit
- pattern_load  in  1  load pattern_in on this edge
- pattern_in  in  PAT_W  new pattern, MSB first
- count_clr  in  1  synchronous clear of match_count
- state  out  PW=clog2(PAT_W+1)  current match progress (matched prefix length)
- out  out  1  one-cycle match pulse
- match_count  out  CNT_W  saturating count of matches

Behaviour:
- Reset (reset=0, async, applies immediately):
  - pattern register = PAT_RST
  - history register = 0, fill counter = 0
  - state = 0, out = 0, match_count = 0
- Internal state:
  - hist[PAT_W-1:0] shift register; new bit enters at LSB.
  - fill in 0..PAT_W: number of valid history bits.
- Accepted bit (in_valid=1, pattern_load=0) at a rising edge:
  - hist_n = {hist[PAT_W-2:0], input_bit}
  - fill_n = min(fill+1, PAT_W)
  - k = largest value in 0..fill_n with hist_n[k-1:0] == pattern[PAT_W-1:PAT_W-k]
  - state <= k
  - out <= (k == PAT_W)
- Latency: out is high during the single cycle after the edge that accepted the final pattern bit.
- No accepted bit on an edge: out <= 0; state, hist and fill hold.
- Match with OVERLAP=0: fill <= 0 on the same edge, so the next match needs PAT_W fresh bits. The next accepted bit computes from fill=0. state shows PAT_W during the out cycle.
- Match with OVERLAP=1: hist and fill are kept, so a suffix of the pattern can begin the next match.
- pattern_load=1:
  - pattern <= pattern_in; hist <= 0; fill <= 0; state <= 0; out <= 0.
  - Has priority over in_valid; a bit presented on the same edge is discarded.
- match_count:
  - Increments on each edge where out is set.
  - Saturates at 2^CNT_W-1; never wraps.
  - count_clr=1 forces 0 on that edge, even if a match occurs on the same edge (clear wins).
- Unknown/X on input_bit while in_valid=0 must not affect state.

Decomposition:
- Package seq_det_pkg:
  - clog2 constant function
  - PW width derivation
  - default PAT_W / PAT_RST / CNT_W constants
- One combinational sub-module, seq_prefix_match:
  - inputs: hist_n, fill_n, pattern
  - output: k (longest prefix-suffix length)
  - parameterised by PAT_W; instantiated once.
- Top level holds the registers, load/overlap control and counter.

Test Plan:
- Release reset, then feed 1,0,0,1,0,0,1 with in_valid=1, PAT_RST=1001, OVERLAP=1 -> out pulses after bit 4 and after bit 7; state sequence 1,2,3,4,2,3,4; match_count=2.
- Same stream with OVERLAP=0 -> single out pulse after bit 4; state 1,2,3,4,0,0,1; match_count=1.
- Pattern 1001 with in_valid low for 3 cycles between bits 2 and 3 -> state holds at 2 during the gap; out still pulses after bit 4.
- pattern_load of 4'b1100 after bits 1,0,0 -> state=0; stream 1,1,0,0 -> out pulses after the fourth bit; the old pattern never matches.
- Drive reset low mid-pattern (state=3), asynchronously between edges -> state, out and match_count go to 0 immediately; next bits 0,0,1 do not produce out.
- CNT_W=2 with 5 overlapping matches of 1001 (stream 1001001001001001) -> match_count reads 1,2,3,3,3. Then count_clr together with a match -> match_count=0 and out=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and width helpers for the serial pattern detector.
package seq_det_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Width needed to hold a prefix length 0..pat_w inclusive.
  function automatic int pw_of(input int pat_w);
    return clog2(pat_w + 1);
  endfunction

  localparam int          DEF_PAT_W   = 4;
  localparam logic [15:0] DEF_PAT_RST = 16'h0009;
  localparam int          DEF_CNT_W   = 8;

endpackage

// File: rtl/seq_prefix_match.sv
// Longest k such that the newest k history bits equal the first k pattern bits,
// limited to the number of history bits that are actually valid.
module seq_prefix_match
  import seq_det_pkg::*;
#(
  parameter  int PAT_W = DEF_PAT_W,
  localparam int PW    = pw_of(PAT_W)
) (
  input  logic [PAT_W-1:0] hist_n,
  input  logic [PW-1:0]    fill_n,
  input  logic [PAT_W-1:0] pattern,
  output logic [PW-1:0]    k
);

  logic [PAT_W:1] cand;

  // One comparator per candidate length; the pattern MSB is matched first.
  for (genvar j = 1; j <= PAT_W; j++) begin : g_len
    localparam logic [PW-1:0] LEN = PW'(j);
    assign cand[j] = (fill_n >= LEN) && (hist_n[j-1:0] == pattern[PAT_W-1 -: j]);
  end

  always_comb begin
    k = '0;
    for (int j = 1; j <= PAT_W; j++)
      if (cand[j]) k = PW'(j);
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector: run-time loadable pattern, optional overlap,
// input qualifier and saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter  int             PAT_W   = DEF_PAT_W,
  parameter  logic [PAT_W-1:0] PAT_RST = PAT_W'(DEF_PAT_RST),
  parameter  bit             OVERLAP = 1'b1,
  parameter  int             CNT_W   = DEF_CNT_W,
  localparam int             PW      = pw_of(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             input_bit,
  input  logic             pattern_load,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             count_clr,
  output logic [PW-1:0]    state,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [PW-1:0] FILL_MAX = PW'(PAT_W);

  logic [PAT_W-1:0] pattern;
  logic [PAT_W-1:0] hist, hist_n;
  logic [PW-1:0]    fill, fill_n;
  logic [PW-1:0]    k;
  logic             accept, hit;

  always_comb begin
    hist_n = {hist[PAT_W-2:0], input_bit};
    fill_n = (fill == FILL_MAX) ? fill : fill + 1'b1;
    accept = in_valid && !pattern_load;
    hit    = (k == FILL_MAX);
  end

  seq_prefix_match #(.PAT_W(PAT_W)) u_match (
    .hist_n  (hist_n),
    .fill_n  (fill_n),
    .pattern (pattern),
    .k       (k)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern <= PAT_RST;
      hist    <= '0;
      fill    <= '0;
      state   <= '0;
      out     <= 1'b0;
    end else if (pattern_load) begin
      pattern <= pattern_in;
      hist    <= '0;
      fill    <= '0;
      state   <= '0;
      out     <= 1'b0;
    end else if (in_valid) begin
      hist  <= hist_n;
      // Non-overlap mode forgets history so the next match needs PAT_W fresh bits.
      fill  <= (hit && !OVERLAP) ? '0 : fill_n;
      state <= k;
      out   <= hit;
    end else begin
      out <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      match_count <= '0;
    else if (count_clr)
      match_count <= '0;
    else if (accept && hit && (match_count != {CNT_W{1'b1}}))
      match_count <= match_count + 1'b1;
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: three detector builds (overlap, non-overlap, 2-bit counter)
// share one stimulus bus; each phase checks the build it targets.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       input_bit;
  logic       pattern_load;
  logic [3:0] pattern_in;
  logic       count_clr;

  logic [2:0] st_ovl, st_nov, st_c2;
  logic       out_ovl, out_nov, out_c2;
  logic [7:0] cnt_ovl, cnt_nov;
  logic [1:0] cnt_c2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_detector_param u_ovl (
    .clk(clk), .reset(reset), .in_valid(in_valid), .input_bit(input_bit),
    .pattern_load(pattern_load), .pattern_in(pattern_in), .count_clr(count_clr),
    .state(st_ovl), .out(out_ovl), .match_count(cnt_ovl)
  );

  seq_detector_param #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .reset(reset), .in_valid(in_valid), .input_bit(input_bit),
    .pattern_load(pattern_load), .pattern_in(pattern_in), .count_clr(count_clr),
    .state(st_nov), .out(out_nov), .match_count(cnt_nov)
  );

  seq_detector_param #(.CNT_W(2)) u_c2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .input_bit(input_bit),
    .pattern_load(pattern_load), .pattern_in(pattern_in), .count_clr(count_clr),
    .state(st_c2), .out(out_c2), .match_count(cnt_c2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one accepted bit, then sample 1 time unit after the edge.
  task automatic step(input logic b, input logic clr);
    in_valid  = 1'b1;
    input_bit = b;
    count_clr = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    input_bit = 1'bx;
    count_clr = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
  endtask

  int         exp_s_ovl [7] = '{1, 2, 3, 4, 2, 3, 4};
  int         exp_o_ovl [7] = '{0, 0, 0, 1, 0, 0, 1};
  int         exp_s_nov [7] = '{1, 2, 3, 4, 0, 0, 1};
  int         exp_o_nov [7] = '{0, 0, 0, 1, 0, 0, 0};
  logic [6:0] stream_a  = 7'b1001001;
  logic [15:0] stream_e = 16'b1001001001001001;
  int         c2_exp;

  initial begin
    reset = 1'b0; in_valid = 1'b0; input_bit = 1'b0;
    pattern_load = 1'b0; pattern_in = 4'b0000; count_clr = 1'b0;

    // Reset state
    #12;
    chk("rst_state", st_ovl, 0);
    chk("rst_out",   out_ovl, 0);
    chk("rst_cnt",   cnt_ovl, 0);
    reset = 1'b1;
    idle();

    // Overlap vs non-overlap on 1001001
    for (int i = 0; i < 7; i++) begin
      step(stream_a[6-i], 1'b0);
      chk($sformatf("ovl_state[%0d]", i), st_ovl, exp_s_ovl[i]);
      chk($sformatf("ovl_out[%0d]", i),   out_ovl, exp_o_ovl[i]);
      chk($sformatf("nov_state[%0d]", i), st_nov, exp_s_nov[i]);
      chk($sformatf("nov_out[%0d]", i),   out_nov, exp_o_nov[i]);
    end
    chk("ovl_cnt_a", cnt_ovl, 2);
    chk("nov_cnt_a", cnt_nov, 1);
    idle();
    chk("ovl_out_drop", out_ovl, 0);
    chk("ovl_state_hold", st_ovl, 4);

    // in_valid gap between bits 2 and 3 (input_bit is X while idle)
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("gap_state[%0d]", i), st_ovl, 2);
      chk($sformatf("gap_out[%0d]", i),   out_ovl, 0);
    end
    step(1'b0, 1'b0);
    chk("gap_state3", st_ovl, 3);
    step(1'b1, 1'b0);
    chk("gap_state4", st_ovl, 4);
    chk("gap_out4",   out_ovl, 1);

    // Run-time pattern load, bit on the same edge is dropped
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("pre_load_state", st_ovl, 3);
    pattern_load = 1'b1; pattern_in = 4'b1100; in_valid = 1'b1; input_bit = 1'b1;
    @(posedge clk);
    #1;
    pattern_load = 1'b0; in_valid = 1'b0; input_bit = 1'bx;
    chk("load_state", st_ovl, 0);
    chk("load_out",   out_ovl, 0);
    step(1'b1, 1'b0); chk("ld_s1", st_ovl, 1); chk("ld_o1", out_ovl, 0);
    step(1'b1, 1'b0); chk("ld_s2", st_ovl, 2); chk("ld_o2", out_ovl, 0);
    step(1'b0, 1'b0); chk("ld_s3", st_ovl, 3); chk("ld_o3", out_ovl, 0);
    step(1'b0, 1'b0); chk("ld_s4", st_ovl, 4); chk("ld_o4", out_ovl, 1);
    for (int i = 0; i < 4; i++) begin
      step(stream_a[6-i], 1'b0);
      chk($sformatf("old_pat_out[%0d]", i), out_ovl, 0);
    end

    // Asynchronous reset between edges, mid-pattern
    do_reset();
    for (int i = 0; i < 6; i++) step(stream_a[6-i], 1'b0);
    chk("pre_arst_state", st_ovl, 3);
    chk("pre_arst_cnt",   cnt_ovl, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_state", st_ovl, 0);
    chk("arst_out",   out_ovl, 0);
    chk("arst_cnt",   cnt_ovl, 0);
    chk("arst_pat_restored_state", st_nov, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    step(1'b0, 1'b0); chk("post_s0", st_ovl, 0); chk("post_o0", out_ovl, 0);
    step(1'b0, 1'b0); chk("post_s1", st_ovl, 0); chk("post_o1", out_ovl, 0);
    step(1'b1, 1'b0); chk("post_s2", st_ovl, 1); chk("post_o2", out_ovl, 0);

    // Saturating 2-bit counter over five overlapping matches
    do_reset();
    c2_exp = 0;
    for (int i = 0; i < 16; i++) begin
      step(stream_e[15-i], 1'b0);
      if ((i % 3) == 0 && i != 0) begin
        if (c2_exp < 3) c2_exp++;
        chk($sformatf("c2_out[%0d]", i), out_c2, 1);
        chk($sformatf("c2_cnt[%0d]", i), cnt_c2, c2_exp);
      end else begin
        chk($sformatf("c2_out[%0d]", i), out_c2, 0);
      end
    end
    chk("c2_ovl_cnt", cnt_ovl, 5);
    // Clear on the same edge as a match: clear wins, pulse still fires
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("clr_out", out_c2, 1);
    chk("clr_cnt", cnt_c2, 0);
    chk("clr_cnt_ovl", cnt_ovl, 0);
    step(1'b0, 1'b0);
    chk("clr_hold", cnt_c2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
